// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner.
//   db_state_t         : per-channel debounce FSM state
//   DB_CYCLES_DEFAULT  : default stability count (cycles) for accepting a level change
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LO,  // debounced low, input quiet
    ARM_HI,   // input went high, counting toward acceptance
    HOLD_HI,  // debounced high
    ARM_LO    // input went low, counting toward release
  } db_state_t;

  localparam int unsigned DB_CYCLES_DEFAULT = 16;

endpackage : btn_pkg

// File: rtl/button_conditioner_if.sv
// Per-button signal bundle between a raw pushbutton and its conditioned outputs.
//   raw   : asynchronous raw button level
//   lvl   : debounced level
//   pulse : one-cycle press pulse
// Modports:
//   master : button/consumer side (drives raw, observes lvl/pulse)
//   slave  : conditioner side (observes raw, drives lvl/pulse)
interface button_conditioner_if;

  logic raw;
  logic lvl;
  logic pulse;

  modport master (output raw, input lvl, input pulse);
  modport slave  (input raw, output lvl, output pulse);

endinterface : button_conditioner_if

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, stability counter, 4-state
// debounce FSM, registered debounced level and registered press pulse.
// Ports:
//   clk : clock, all state on rising edge
//   rs  : synchronous active-low reset
//   ch  : slave side of the button bundle (raw in, lvl/pulse out)
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rs,
  button_conditioner_if.slave  ch
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (!rs) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= ch.raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
    end
  end

  // Entering an ARM state already counts the first stable cycle (counter=1),
  // so acceptance happens on the DB_CYCLES-th consecutive stable sample.
  // The counter leaves the ARM state at CNT_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = ARM_HI;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HOLD_HI;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD_HI: begin
        if (!s2_q) begin
          state_d = ARM_LO;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_LO: begin
        if (s2_q) begin
          state_d = HOLD_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE_LO;
    endcase

    // Outputs are decoded from the next state so the registered level and
    // pulse line up with the state register update.
    lvl_d   = (state_d == HOLD_HI) || (state_d == ARM_LO);
    pulse_d = (state_q == ARM_HI) && (state_d == HOLD_HI);
  end

  assign ch.lvl   = lvl_q;
  assign ch.pulse = pulse_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: debounces two asynchronous raw buttons
// and produces a debounced level plus a one-cycle press pulse per channel.
// Ports:
//   clk      : clock
//   rs       : synchronous active-low reset
//   btn1_raw : raw pushbutton 1 (asynchronous)
//   btn2_raw : raw pushbutton 2 (asynchronous)
//   p1, p2   : one-cycle press pulses (to downstream FSM p1/p2 inputs)
//   lvl1,lvl2: debounced levels
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rs,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic p1,
  output logic p2,
  output logic lvl1,
  output logic lvl2
);

  button_conditioner_if ch1_if ();
  button_conditioner_if ch2_if ();

  assign ch1_if.raw = btn1_raw;
  assign ch2_if.raw = btn2_raw;

  debounce_channel #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_ch1 (
    .clk (clk),
    .rs  (rs),
    .ch  (ch1_if.slave)
  );

  debounce_channel #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_ch2 (
    .clk (clk),
    .rs  (rs),
    .ch  (ch2_if.slave)
  );

  assign p1   = ch1_if.pulse;
  assign lvl1 = ch1_if.lvl;
  assign p2   = ch2_if.pulse;
  assign lvl2 = ch2_if.lvl;

endmodule : button_conditioner
